// File: rtl/ro_meas_ctrl.sv
// rtl/ro_meas_ctrl.sv - ring-oscillator measurement sequencer: settle, gated edge count, snapshot, result handshake
module ro_meas_ctrl #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 20,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              ro_out,
    input  logic [62:0]       buffer,
    output logic              ro_activate,
    output logic              busy,
    output logic [CNT_W-1:0]  result_cnt,
    output logic [62:0]       result_snap,
    output logic              overflow,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_SNAP    = 3'd3;
    localparam logic [2:0] ST_RESULT  = 3'd4;

    logic [2:0]        state_q,  state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [GATE_W-1:0] win_q,    win_d;
    logic [CNT_W-1:0]  edge_q,   edge_d;
    logic              ovf_q,    ovf_d;
    logic [2:0]        sync_q,   sync_d;
    logic [CNT_W-1:0]  res_cnt_q,  res_cnt_d;
    logic [62:0]       res_snap_q, res_snap_d;
    logic              act_q,    act_d;
    logic              valid_q,  valid_d;
    logic              rise;

    // sync_q[1] is the second synchroniser stage, sync_q[2] its one-cycle history
    assign rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        win_d      = win_q;
        edge_d     = edge_q;
        ovf_d      = ovf_q;
        sync_d     = {sync_q[1:0], ro_out};
        res_cnt_d  = res_cnt_q;
        res_snap_d = res_snap_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort && !valid_q) begin
                    state_d  = ST_SETTLE;
                    settle_d = SET_W'(SETTLE - 1);
                    // window counter holds remaining cycles minus one; zero length runs one cycle
                    win_d    = (gate_len == '0) ? '0 : gate_len - GATE_W'(1);
                    edge_d   = '0;
                    ovf_d    = 1'b0;
                    sync_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (settle_q == '0) begin
                    state_d = ST_MEASURE;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_MEASURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (rise) begin
                        if (edge_q == '1) begin
                            ovf_d = 1'b1;
                        end else begin
                            edge_d = edge_q + CNT_W'(1);
                        end
                    end
                    if (win_q == '0) begin
                        state_d = ST_SNAP;
                    end else begin
                        win_d = win_q - GATE_W'(1);
                    end
                end
            end
            ST_SNAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    res_cnt_d  = edge_q;
                    res_snap_d = buffer;
                    state_d    = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (abort || result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // both flags are decoded from the next state so the outputs come straight from flops
        act_d   = (state_d == ST_SETTLE) || (state_d == ST_MEASURE) || (state_d == ST_SNAP);
        valid_d = (state_d == ST_RESULT);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            win_q      <= '0;
            edge_q     <= '0;
            ovf_q      <= 1'b0;
            sync_q     <= '0;
            res_cnt_q  <= '0;
            res_snap_q <= '0;
            act_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            win_q      <= win_d;
            edge_q     <= edge_d;
            ovf_q      <= ovf_d;
            sync_q     <= sync_d;
            res_cnt_q  <= res_cnt_d;
            res_snap_q <= res_snap_d;
            act_q      <= act_d;
            valid_q    <= valid_d;
        end
    end

    assign ro_activate  = act_q;
    assign busy         = (state_q != ST_IDLE);
    assign result_cnt   = res_cnt_q;
    assign result_snap  = res_snap_q;
    assign overflow     = ovf_q;
    assign result_valid = valid_q;

endmodule

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
Measurement sequencer for one ring-oscillator tile. On a start request it enables the oscillator through ro_activate and waits a settle period. It then counts rising edges of ro_out over a programmable window of clk cycles and captures one 63-bit stage snapshot. The count and snapshot are returned through a valid/ready result port. It sits between the tile's host/config logic and the ring oscillator instance.

Parameters:
GATE_W, 16, width of gate_len (window length in clk cycles)
CNT_W, 20, width of edge counter / result_cnt
SETTLE, 4, clk cycles between ro_activate rise and window open (min 2)

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous, active-high reset (asserted = 1, codebase naming retained)
start  input  1  single-cycle measurement request
abort  input  1  cancel measurement in progress
gate_len  input  GATE_W  window length in clk cycles, sampled on accepted start
ro_out  input  1  oscillator output, asynchronous to clk
buffer  input  63  registered stage snapshot from the oscillator
ro_activate  output  1  oscillator enable request
busy  output  1  high in any state except IDLE
result_cnt  output  CNT_W  rising edges counted in window
result_snap  output  63  buffer value captured at window close
overflow  output  1  edge counter saturated during window
result_valid  output  1  result available
result_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, rst_n=1): state IDLE; ro_activate, busy, result_valid, overflow = 0; result_cnt, result_snap = 0; synchroniser flops = 0.
- ro_out passes through a 2-flop synchroniser plus one history flop. A rising edge is s2=1 & s3=0. All three flops clear on reset and on entry to SETTLE.
- FSM states:
  - IDLE: start=1 & abort=0 & result_valid=0 -> latch gate_len (0 treated as 1), clear counter and overflow, go to SETTLE. Start is ignored in every other case.
  - SETTLE: ro_activate=1. Runs exactly SETTLE cycles, then goes to MEASURE.
  - MEASURE: ro_activate=1. Runs exactly gate_len cycles and counts synchronised rising edges. The counter saturates at 2^CNT_W-1 and sets overflow sticky. Then goes to SNAP.
  - SNAP: one cycle with ro_activate=1. result_snap <= buffer, result_cnt <= counter. Go to RESULT; ro_activate drops to 0 on entry to RESULT.
  - RESULT: result_valid=1, busy=1, outputs stable. On result_valid & result_ready, go to IDLE with result_valid=0 next cycle. result_cnt, result_snap and overflow hold until the next accepted start.
- Latency: accepted start to result_valid high = SETTLE + gate_len + 2 clk cycles.
- Only edges seen in MEASURE cycles are counted. An edge detected in the same cycle as the MEASURE->SNAP transition is counted.
- abort: from SETTLE, MEASURE or SNAP, return to IDLE the next cycle. ro_activate=0, result_valid stays 0, result registers unchanged. In RESULT, abort acts as a ready and drops result_valid. abort beats start in the same cycle.
- gate_len changes outside IDLE have no effect.
- ro_activate is a registered output and is glitch-free.

Test Plan:
- Reset mid-MEASURE (rst_n pulsed at cycle 10 of gate_len=50) -> all outputs 0 immediately; IDLE; next start runs normally.
- ro_out driven synchronously, toggling every 2 clk (period 4); SETTLE=4; gate_len=100; start -> result_valid at cycle 106 after start; result_cnt=25; overflow=0; result_snap equals buffer value in the SNAP cycle.
- ro_out held 0; gate_len=0 -> window of 1 cycle; result_cnt=0; result_valid at cycle 7 after start.
- CNT_W=4 build; ro_out period 4; gate_len=100 -> result_cnt=15, overflow=1.
- result_ready held 0 for 20 cycles; start pulsed during that time -> ignored; result stable; after ready=1, result_valid=0 next cycle, busy=0.
- abort at cycle 3 of MEASURE -> ro_activate=0 and busy=0 next cycle; no result_valid; previous result_cnt retained. Start and abort in the same IDLE cycle -> stays IDLE.
